// File: rtl/plic_gateway_ctrl.sv
// plic_gateway_ctrl: per-source gateway and claim/complete sequencer for one PLIC target; PLIC_EDGE_TRIG_EN adds edge_sel_i
`ifndef PLIC_SOURCE_COUNT
`define PLIC_SOURCE_COUNT 8
`endif
`ifndef PLIC_SOURCE_WIDTH
`define PLIC_SOURCE_WIDTH 4
`endif
module plic_gateway_ctrl #(
  parameter int SRC_CNT = `PLIC_SOURCE_COUNT,
  parameter int SRC_W   = `PLIC_SOURCE_WIDTH,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SRC_CNT-1:0] irq_src_i,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic [SRC_CNT-1:0] edge_sel_i,
`endif
  input  logic [SRC_W-1:0]   sel_idx_i,
  input  logic               claim_req_i,
  output logic               claim_ack_o,
  output logic [SRC_W-1:0]   claim_id_o,
  input  logic               complete_req_i,
  input  logic [SRC_W-1:0]   complete_id_i,
  output logic [SRC_CNT-1:0] irq_pending_o,
  output logic [SRC_CNT-1:0] irq_insrv_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, INSRV = 2'd2} state_e;
  state_e state_q [SRC_CNT];
  state_e state_d [SRC_CNT];
  logic [SRC_CNT-1:0] sync1_q, sync1_d, sync2_q, sync2_d, src_s, trig, rearm, clm_hit, cmp_hit;
  logic claim_ack_q, claim_ack_d;
  logic [SRC_W-1:0] claim_id_q, claim_id_d;
`ifdef PLIC_EDGE_TRIG_EN
  logic [SRC_CNT-1:0] edge_q, edge_d, defer_q, defer_d, rise;
`endif
  // synchronise sources and turn them into per-source pend triggers
  always_comb begin
    sync1_d = irq_src_i;
    sync2_d = sync1_q;
    src_s = SYNC_EN ? sync2_q : irq_src_i;
`ifdef PLIC_EDGE_TRIG_EN
    edge_d = src_s;
    rise = edge_sel_i & src_s & ~edge_q;
    trig = (edge_sel_i & rise) | (~edge_sel_i & src_s);
    rearm = defer_q | rise;
`else
    trig = src_s;
    rearm = '0;
`endif
  end
  // per-source state transitions, claim acceptance and status decode
  always_comb begin
    for (int i = 0; i < SRC_CNT; i++) begin
      clm_hit[i] = claim_req_i && sel_idx_i == SRC_W'(i + 1) && state_q[i] == PEND;
      cmp_hit[i] = complete_req_i && complete_id_i == SRC_W'(i + 1) && state_q[i] == INSRV;
      state_d[i] = clm_hit[i] ? INSRV :
                   cmp_hit[i] ? (rearm[i] ? PEND : IDLE) :
                   (state_q[i] == IDLE && trig[i]) ? PEND : state_q[i];
      irq_pending_o[i] = state_q[i] == PEND;
      irq_insrv_o[i] = state_q[i] == INSRV;
    end
`ifdef PLIC_EDGE_TRIG_EN
    defer_d = '0;
    for (int i = 0; i < SRC_CNT; i++)
      defer_d[i] = state_q[i] == INSRV && !cmp_hit[i] && (defer_q[i] || rise[i]);
`endif
    claim_ack_d = claim_req_i;
    claim_id_d = |clm_hit ? sel_idx_i : '0;
    claim_ack_o = claim_ack_q;
    claim_id_o = claim_id_q;
  end
  // state register; reset drops any claim or complete in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      claim_ack_q <= 1'b0;
      claim_id_q <= '0;
      for (int i = 0; i < SRC_CNT; i++) state_q[i] <= IDLE;
`ifdef PLIC_EDGE_TRIG_EN
      edge_q <= '0;
      defer_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      claim_ack_q <= claim_ack_d;
      claim_id_q <= claim_id_d;
      for (int i = 0; i < SRC_CNT; i++) state_q[i] <= state_d[i];
`ifdef PLIC_EDGE_TRIG_EN
      edge_q <= edge_d;
      defer_q <= defer_d;
`endif
    end
  end
endmodule

// File: tb/tb_plic_gateway_ctrl.sv
// tb_plic_gateway_ctrl: randomized and directed checks of plic_gateway_ctrl against a behavioural model
module tb_plic_gateway_ctrl;
  localparam int N = 8;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] irq_src_i = '0;
  logic [W-1:0] sel_idx_i = '0;
  logic claim_req_i = 1'b0;
  logic claim_ack_o;
  logic [W-1:0] claim_id_o;
  logic complete_req_i = 1'b0;
  logic [W-1:0] complete_id_i = '0;
  logic [N-1:0] irq_pending_o;
  logic [N-1:0] irq_insrv_o;
`ifdef PLIC_EDGE_TRIG_EN
  logic [N-1:0] edge_sel_i = '0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  bit [N-1:0] m_pend, m_ins, dl0, dl1, m_prev, m_defer;
  bit m_ack;
  logic [W-1:0] m_id;

  always #5 clk = ~clk;

  plic_gateway_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_src_i(irq_src_i),
`ifdef PLIC_EDGE_TRIG_EN
    .edge_sel_i(edge_sel_i),
`endif
    .sel_idx_i(sel_idx_i), .claim_req_i(claim_req_i), .claim_ack_o(claim_ack_o),
    .claim_id_o(claim_id_o), .complete_req_i(complete_req_i), .complete_id_i(complete_id_i),
    .irq_pending_o(irq_pending_o), .irq_insrv_o(irq_insrv_o)
  );

  function automatic void model_reset();
    m_pend = '0; m_ins = '0; dl0 = '0; dl1 = '0; m_prev = '0; m_defer = '0; m_ack = 0; m_id = '0;
  endfunction

  // advance one clock, updating the model from the gateway rules with the inputs currently driven
  task automatic step();
    bit [N-1:0] s = dl1;
    bit acc;
    int cp, sel;
    sel = int'(sel_idx_i);
    acc = claim_req_i && sel >= 1 && sel <= N && m_pend[sel-1];
    cp = (complete_req_i && complete_id_i >= 1 && complete_id_i <= N && m_ins[complete_id_i-1]) ? int'(complete_id_i) : 0;
    for (int i = 0; i < N; i++) begin
      bit trig = s[i];
      bit rise = 0;
`ifdef PLIC_EDGE_TRIG_EN
      rise = edge_sel_i[i] && s[i] && !m_prev[i];
      trig = edge_sel_i[i] ? rise : s[i];
`endif
      if (acc && i == sel - 1) begin m_pend[i] = 0; m_ins[i] = 1; end
      else if (cp == i + 1) begin m_ins[i] = 0; m_pend[i] = m_defer[i] | rise; m_defer[i] = 0; end
      else if (m_ins[i]) m_defer[i] = m_defer[i] | rise;
      else if (!m_pend[i] && trig) m_pend[i] = 1;
    end
    m_prev = s;
    m_ack = claim_req_i;
    m_id = acc ? sel_idx_i : '0;
    dl1 = dl0;
    dl0 = irq_src_i;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_chk += 4;
    if (claim_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", claim_ack_o); end
    if (claim_id_o !== '0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", claim_id_o); end
    if (irq_pending_o !== '0) begin n_fail++; $display("FAIL reset_pend got=%b exp=0", irq_pending_o); end
    if (irq_insrv_o !== '0) begin n_fail++; $display("FAIL reset_insrv got=%b exp=0", irq_insrv_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sync_latency();
    irq_src_i = 8'b0000_0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_chk++;
      if (irq_pending_o !== (k == 3 ? 8'b0000_0100 : 8'b0)) begin
        n_fail++; $display("FAIL sync_edge%0d pend got=%b exp=%b", k, irq_pending_o, k == 3 ? 8'b100 : 8'b0);
      end
    end
  endtask

  task automatic test_claim();
    sel_idx_i = 3; claim_req_i = 1;
    step();
    claim_req_i = 0;
    n_chk += 3;
    if (claim_ack_o !== 1'b1 || claim_id_o !== 4'd3) begin n_fail++; $display("FAIL claim3 ack/id got=%b/%0d exp=1/3", claim_ack_o, claim_id_o); end
    if (irq_pending_o[2] !== 1'b0) begin n_fail++; $display("FAIL claim3 pend2 got=%b exp=0", irq_pending_o[2]); end
    if (irq_insrv_o[2] !== 1'b1) begin n_fail++; $display("FAIL claim3 insrv2 got=%b exp=1", irq_insrv_o[2]); end
    step();
    n_chk++;
    if (claim_ack_o !== 1'b0) begin n_fail++; $display("FAIL claim3 ack_drop got=%b exp=0", claim_ack_o); end
  endtask

  task automatic test_bad_claim();
    logic [W-1:0] ids [2] = '{4'd0, 4'd5};
    for (int k = 0; k < 2; k++) begin
      sel_idx_i = ids[k]; claim_req_i = 1;
      step();
      claim_req_i = 0;
      n_chk += 2;
      if (claim_ack_o !== 1'b1 || claim_id_o !== 4'd0) begin n_fail++; $display("FAIL bad_claim%0d ack/id got=%b/%0d exp=1/0", ids[k], claim_ack_o, claim_id_o); end
      if (irq_insrv_o !== m_ins || irq_pending_o !== m_pend) begin
        n_fail++; $display("FAIL bad_claim%0d state got=%b/%b exp=%b/%b", ids[k], irq_pending_o, irq_insrv_o, m_pend, m_ins);
      end
    end
  endtask

  task automatic test_complete();
    complete_req_i = 1; complete_id_i = 3;
    step();
    complete_req_i = 0;
    n_chk++;
    if (irq_insrv_o[2] !== 1'b0 || irq_pending_o[2] !== 1'b0) begin n_fail++; $display("FAIL complete3 got pend/insrv=%b/%b exp=0/0", irq_pending_o[2], irq_insrv_o[2]); end
    step();
    n_chk++;
    if (irq_pending_o[2] !== 1'b1) begin n_fail++; $display("FAIL complete3 repend got=%b exp=1", irq_pending_o[2]); end
    sel_idx_i = 3; claim_req_i = 1;
    step();
    claim_req_i = 0; complete_req_i = 1; complete_id_i = 4;
    step();
    complete_req_i = 0;
    n_chk++;
    if (irq_insrv_o !== 8'b0000_0100) begin n_fail++; $display("FAIL complete4_ignored insrv got=%b exp=00000100", irq_insrv_o); end
  endtask

  task automatic test_same_cycle();
    irq_src_i = 8'b0000_0101;
    repeat (3) step();
    sel_idx_i = 1; claim_req_i = 1; complete_req_i = 1; complete_id_i = 3;
    step();
    claim_req_i = 0; complete_req_i = 0;
    n_chk += 2;
    if (irq_insrv_o[0] !== 1'b1 || irq_insrv_o[2] !== 1'b0) begin n_fail++; $display("FAIL same_cycle insrv got=%b exp=xxxxx0x1", irq_insrv_o); end
    if (claim_ack_o !== 1'b1 || claim_id_o !== 4'd1) begin n_fail++; $display("FAIL same_cycle ack/id got=%b/%0d exp=1/1", claim_ack_o, claim_id_o); end
  endtask

  task automatic test_back_to_back();
    irq_src_i = 8'hF0;
    repeat (3) step();
    irq_src_i = '0;
    for (int k = 5; k <= 8; k++) begin
      sel_idx_i = W'(k); claim_req_i = 1;
      step();
      n_chk += 2;
      if (claim_ack_o !== 1'b1 || claim_id_o !== W'(k)) begin n_fail++; $display("FAIL b2b claim%0d ack/id got=%b/%0d exp=1/%0d", k, claim_ack_o, claim_id_o, k); end
      if (irq_insrv_o !== m_ins) begin n_fail++; $display("FAIL b2b claim%0d insrv got=%b exp=%b", k, irq_insrv_o, m_ins); end
    end
    claim_req_i = 0;
    for (int k = 5; k <= 8; k++) begin
      complete_req_i = 1; complete_id_i = W'(k);
      step();
    end
    complete_req_i = 0;
    n_chk++;
    if (irq_insrv_o[7:4] !== 4'b0) begin n_fail++; $display("FAIL b2b completes insrv got=%b exp=0000xxxx", irq_insrv_o); end
  endtask

  task automatic test_async_reset();
    irq_src_i = 8'b0000_1000;
    repeat (3) step();
    sel_idx_i = 4; claim_req_i = 1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_chk += 2;
    if (irq_pending_o !== '0 || irq_insrv_o !== '0) begin n_fail++; $display("FAIL async_reset state got=%b/%b exp=0/0", irq_pending_o, irq_insrv_o); end
    @(posedge clk); #1;
    claim_req_i = 0;
    rst_n = 1'b1;
    if (claim_ack_o !== 1'b0) begin n_fail++; $display("FAIL async_reset ack got=%b exp=0", claim_ack_o); end
    step();
    n_chk++;
    if (claim_ack_o !== 1'b0) begin n_fail++; $display("FAIL async_reset late_ack got=%b exp=0", claim_ack_o); end
  endtask

  task automatic test_random();
`ifdef PLIC_EDGE_TRIG_EN
    edge_sel_i = '0;
`endif
    for (int c = 0; c < 400; c++) begin
      irq_src_i = N'($urandom);
      claim_req_i = $urandom_range(0, 9) < 3;
      sel_idx_i = W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < N; i++) if (m_pend[i] && $urandom_range(0, 2) == 0) sel_idx_i = W'(i + 1);
      complete_req_i = $urandom_range(0, 9) < 3;
      complete_id_i = W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        for (int i = 0; i < N; i++) if (m_ins[i] && $urandom_range(0, 2) == 0) complete_id_i = W'(i + 1);
      step();
      n_chk += 4;
      if (claim_ack_o !== m_ack) begin n_fail++; $display("FAIL rand%0d ack got=%b exp=%b", c, claim_ack_o, m_ack); end
      if (m_ack && claim_id_o !== m_id) begin n_fail++; $display("FAIL rand%0d id got=%0d exp=%0d", c, claim_id_o, m_id); end
      if (irq_pending_o !== m_pend) begin n_fail++; $display("FAIL rand%0d pend got=%b exp=%b", c, irq_pending_o, m_pend); end
      if (irq_insrv_o !== m_ins) begin n_fail++; $display("FAIL rand%0d insrv got=%b exp=%b", c, irq_insrv_o, m_ins); end
    end
    claim_req_i = 0; complete_req_i = 0;
  endtask

`ifdef PLIC_EDGE_TRIG_EN
  task automatic test_edge();
    irq_src_i = '0;
    repeat (4) step();
    edge_sel_i = 8'b0000_0010;
    irq_src_i = 8'b10; step(); irq_src_i = 0;
    repeat (3) step();
    n_chk++;
    if (irq_pending_o[1] !== 1'b1) begin n_fail++; $display("FAIL edge first_pulse pend got=%b exp=1", irq_pending_o[1]); end
    sel_idx_i = 2; claim_req_i = 1; step(); claim_req_i = 0;
    irq_src_i = 8'b10; step(); irq_src_i = 0; step();
    irq_src_i = 8'b10; step(); irq_src_i = 0;
    repeat (3) step();
    complete_req_i = 1; complete_id_i = 2; step(); complete_req_i = 0;
    n_chk++;
    if (irq_pending_o[1] !== 1'b1 || irq_insrv_o[1] !== 1'b0) begin n_fail++; $display("FAIL edge deferred got pend/insrv=%b/%b exp=1/0", irq_pending_o[1], irq_insrv_o[1]); end
    claim_req_i = 1; step(); claim_req_i = 0;
    complete_req_i = 1; step(); complete_req_i = 0;
    repeat (3) step();
    n_chk++;
    if (irq_pending_o[1] !== 1'b0 || irq_pending_o !== m_pend) begin n_fail++; $display("FAIL edge lost_pulse pend got=%b exp=%b", irq_pending_o, m_pend); end
  endtask
`endif

  initial begin
    test_reset();
    test_sync_latency();
    test_claim();
    test_bad_claim();
    test_complete();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef PLIC_EDGE_TRIG_EN
    test_edge();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
